// File: rtl/generic_cache.sv
// 2-way set-associative, write-back / write-allocate cache with LRU replacement.
// One request in flight: hc side is word-wide, lc side moves whole lines.
module generic_cache #(
   parameter int W         = 64,
   parameter int LINE_BITS = 512,
   parameter int WORD_BITS = 64,
   parameter int C         = 8192,
   parameter int WAYS      = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_N_in,
   input  logic                 cs_in,
   input  logic                 flush_in,
   input  logic                 hc_valid_in,
   output logic                 hc_ready_out,
   input  logic [W-1:0]         hc_addr_in,
   input  logic [WORD_BITS-1:0] hc_value_in,
   input  logic                 hc_we_in,
   output logic                 hc_valid_out,
   input  logic                 hc_ready_in,
   output logic [W-1:0]         hc_addr_out,
   output logic [WORD_BITS-1:0] hc_value_out,
   output logic                 hc_we_out,
   output logic                 lc_valid_out,
   input  logic                 lc_ready_in,
   output logic [W-1:0]         lc_addr_out,
   output logic [LINE_BITS-1:0] lc_value_out,
   output logic                 we_out,
   input  logic                 lc_valid_in,
   output logic                 lc_ready_out,
   input  logic [W-1:0]         lc_addr_in,
   input  logic [LINE_BITS-1:0] lc_value_in,
   output logic                 cl_in,
   output logic [LINE_BITS-1:0] cache_line_in
);
   localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
   localparam int SETS      = C / ((LINE_BITS / 8) * WAYS);
   localparam int IDX_BITS  = $clog2(SETS);
   localparam int TAG_BITS  = W - OFF_BITS - IDX_BITS;
   localparam int WSEL_BITS = $clog2(LINE_BITS / WORD_BITS);
   localparam int BYTE_BITS = $clog2(WORD_BITS / 8);
   localparam int WAY_BITS  = $clog2(WAYS);
   localparam int PTR_BITS  = IDX_BITS + WAY_BITS;

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WB         = 3'd1;
   localparam logic [2:0] S_REQ        = 3'd2;
   localparam logic [2:0] S_WAIT_FILL  = 3'd3;
   localparam logic [2:0] S_RESP       = 3'd4;
   localparam logic [2:0] S_FLUSH_SCAN = 3'd5;
   localparam logic [2:0] S_FLUSH_WB   = 3'd6;

   logic [2:0]                     state_reg, state_next;
   logic [W-1:0]                   req_addr_reg;
   logic                           req_we_reg;
   logic [WORD_BITS-1:0]           req_data_reg;
   logic [WAY_BITS-1:0]            victim_reg;
   logic [WORD_BITS-1:0]           resp_value_reg;
   logic                           cl_reg;
   logic [LINE_BITS-1:0]           cl_line_reg;
   logic [PTR_BITS-1:0]            flush_ptr_reg;
   logic [WAYS-1:0][SETS-1:0]      valid_reg, dirty_reg;
   logic [SETS-1:0][WAY_BITS-1:0]  lru_reg;

   logic [TAG_BITS-1:0]  tag_mem  [WAYS][SETS];
   logic [LINE_BITS-1:0] data_mem [WAYS][SETS];

   logic [IDX_BITS-1:0]  acc_idx, req_idx, fl_set;
   logic [TAG_BITS-1:0]  acc_tag, req_tag;
   logic [WSEL_BITS-1:0] acc_wsel, req_wsel;
   logic [WAYS-1:0]      hit_vec;
   logic                 hit, accept, victim_dirty, fl_dirty;
   logic [WAY_BITS-1:0]  hit_way, victim, fl_way;
   logic [LINE_BITS-1:0] hit_line, hit_merged, fill_merged;
   logic                 mem_we, tag_we;
   logic [WAY_BITS-1:0]  mem_way;
   logic [IDX_BITS-1:0]  mem_idx;
   logic [LINE_BITS-1:0] mem_line;
   logic                 unused_ok;

   function automatic logic [LINE_BITS-1:0] merge_word(input logic [LINE_BITS-1:0] line,
                                                       input logic [WSEL_BITS-1:0] sel,
                                                       input logic [WORD_BITS-1:0] word);
      merge_word = line;
      merge_word[sel*WORD_BITS +: WORD_BITS] = word;
   endfunction

   assign unused_ok = ^{lc_addr_in, hc_addr_in[BYTE_BITS-1:0]};

   assign acc_idx  = hc_addr_in[OFF_BITS+IDX_BITS-1:OFF_BITS];
   assign acc_tag  = hc_addr_in[W-1:OFF_BITS+IDX_BITS];
   assign acc_wsel = hc_addr_in[OFF_BITS-1:BYTE_BITS];
   assign req_idx  = req_addr_reg[OFF_BITS+IDX_BITS-1:OFF_BITS];
   assign req_tag  = req_addr_reg[W-1:OFF_BITS+IDX_BITS];
   assign req_wsel = req_addr_reg[OFF_BITS-1:BYTE_BITS];
   assign fl_set   = flush_ptr_reg[PTR_BITS-1:WAY_BITS];
   assign fl_way   = flush_ptr_reg[WAY_BITS-1:0];
   assign fl_dirty = valid_reg[fl_way][fl_set] & dirty_reg[fl_way][fl_set];

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         assign hit_vec[gi] = valid_reg[gi][acc_idx] && (tag_mem[gi][acc_idx] == acc_tag);
      end
   endgenerate

   // Victim: lowest-numbered invalid way, otherwise the LRU way of the set.
   always_comb begin
      hit_way = '0;
      victim  = lru_reg[acc_idx];
      for (int i = 0; i < WAYS; i++)
         if (hit_vec[i]) hit_way = WAY_BITS'(i);
      for (int i = WAYS - 1; i >= 0; i--)
         if (!valid_reg[i][acc_idx]) victim = WAY_BITS'(i);
   end

   assign hit          = |hit_vec;
   assign victim_dirty = valid_reg[victim][acc_idx] & dirty_reg[victim][acc_idx];
   assign hc_ready_out = (state_reg == S_IDLE) & cs_in & ~flush_in & ~rst_N_in;
   assign accept       = hc_valid_in & hc_ready_out;
   assign hit_line     = data_mem[hit_way][acc_idx];
   assign hit_merged   = merge_word(hit_line, acc_wsel, hc_value_in);
   assign fill_merged  = req_we_reg ? merge_word(lc_value_in, req_wsel, req_data_reg) : lc_value_in;

   always_comb begin
      mem_we   = 1'b0;
      tag_we   = 1'b0;
      mem_way  = hit_way;
      mem_idx  = acc_idx;
      mem_line = hit_merged;
      if (state_reg == S_IDLE && accept && hit && hc_we_in) begin
         mem_we = 1'b1;
      end else if (state_reg == S_WAIT_FILL && lc_valid_in) begin
         mem_we   = 1'b1;
         tag_we   = 1'b1;
         mem_way  = victim_reg;
         mem_idx  = req_idx;
         mem_line = fill_merged;
      end
   end

   always_ff @(posedge clk_in) begin
      if (mem_we) data_mem[mem_way][mem_idx] <= mem_line;
      if (tag_we) tag_mem[mem_way][mem_idx] <= req_tag;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:       if (accept) state_next = hit ? S_RESP : (victim_dirty ? S_WB : S_REQ);
                       else if (flush_in) state_next = S_FLUSH_SCAN;
         S_WB:         if (lc_ready_in) state_next = S_REQ;
         S_REQ:        if (lc_ready_in) state_next = S_WAIT_FILL;
         S_WAIT_FILL:  if (lc_valid_in) state_next = S_RESP;
         S_RESP:       if (hc_ready_in) state_next = S_IDLE;
         S_FLUSH_SCAN: if (fl_dirty) state_next = S_FLUSH_WB;
                       else if (&flush_ptr_reg) state_next = S_IDLE;
         S_FLUSH_WB:   if (lc_ready_in) state_next = S_FLUSH_SCAN;
         default:      state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_N_in) begin
         state_reg      <= S_IDLE;
         req_addr_reg   <= '0;
         req_we_reg     <= 1'b0;
         req_data_reg   <= '0;
         victim_reg     <= '0;
         resp_value_reg <= '0;
         cl_reg         <= 1'b0;
         cl_line_reg    <= '0;
         flush_ptr_reg  <= '0;
         valid_reg      <= '0;
         dirty_reg      <= '0;
         lru_reg        <= '0;
      end else begin
         state_reg <= state_next;
         cl_reg    <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               flush_ptr_reg <= '0;
               if (accept) begin
                  req_addr_reg <= hc_addr_in;
                  req_we_reg   <= hc_we_in;
                  req_data_reg <= hc_value_in;
                  victim_reg   <= victim;
                  if (hit) begin
                     lru_reg[acc_idx] <= ~hit_way;
                     resp_value_reg   <= hc_we_in ? hc_value_in
                                                  : hit_line[acc_wsel*WORD_BITS +: WORD_BITS];
                     if (hc_we_in) dirty_reg[hit_way][acc_idx] <= 1'b1;
                  end
               end
            end
            S_WAIT_FILL: if (lc_valid_in) begin
               valid_reg[victim_reg][req_idx] <= 1'b1;
               dirty_reg[victim_reg][req_idx] <= req_we_reg;
               lru_reg[req_idx]               <= ~victim_reg;
               resp_value_reg <= fill_merged[req_wsel*WORD_BITS +: WORD_BITS];
               cl_reg         <= 1'b1;
               cl_line_reg    <= fill_merged;
            end
            S_FLUSH_SCAN: if (!fl_dirty) begin
               flush_ptr_reg <= flush_ptr_reg + 1'b1;
               if (&flush_ptr_reg) begin
                  valid_reg <= '0;
                  dirty_reg <= '0;
                  lru_reg   <= '0;
               end
            end
            S_FLUSH_WB: if (lc_ready_in) dirty_reg[fl_way][fl_set] <= 1'b0;
            default: ;
         endcase
      end
   end

   assign hc_valid_out  = (state_reg == S_RESP);
   assign hc_addr_out   = req_addr_reg;
   assign hc_value_out  = resp_value_reg;
   assign hc_we_out     = req_we_reg;
   assign lc_valid_out  = (state_reg == S_WB) | (state_reg == S_REQ) | (state_reg == S_FLUSH_WB);
   assign we_out        = (state_reg == S_WB) | (state_reg == S_FLUSH_WB);
   assign lc_ready_out  = (state_reg == S_WAIT_FILL);
   assign cl_in         = cl_reg;
   assign cache_line_in = cl_line_reg;

   always_comb begin
      lc_addr_out  = '0;
      lc_value_out = '0;
      case (state_reg)
         S_WB: begin
            lc_addr_out  = {tag_mem[victim_reg][req_idx], req_idx, {OFF_BITS{1'b0}}};
            lc_value_out = data_mem[victim_reg][req_idx];
         end
         S_REQ: lc_addr_out = {req_addr_reg[W-1:OFF_BITS], {OFF_BITS{1'b0}}};
         S_FLUSH_WB: begin
            lc_addr_out  = {tag_mem[fl_way][fl_set], fl_set, {OFF_BITS{1'b0}}};
            lc_value_out = data_mem[fl_way][fl_set];
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_generic_cache.sv
// Directed bench for generic_cache: misses, hits, LRU eviction, dirty writeback,
// chip select, flush and reset during a fill.
module tb_generic_cache;
   logic         clk_in = 1'b0;
   logic         rst_N_in, cs_in, flush_in;
   logic         hc_valid_in, hc_ready_out, hc_we_in;
   logic [63:0]  hc_addr_in, hc_value_in;
   logic         hc_valid_out, hc_ready_in, hc_we_out;
   logic [63:0]  hc_addr_out, hc_value_out;
   logic         lc_valid_out, lc_ready_in, we_out;
   logic [63:0]  lc_addr_out;
   logic [511:0] lc_value_out;
   logic         lc_valid_in, lc_ready_out;
   logic [63:0]  lc_addr_in;
   logic [511:0] lc_value_in;
   logic         cl_in;
   logic [511:0] cache_line_in;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk_in = ~clk_in;

   generic_cache dut (
      .clk_in(clk_in), .rst_N_in(rst_N_in), .cs_in(cs_in), .flush_in(flush_in),
      .hc_valid_in(hc_valid_in), .hc_ready_out(hc_ready_out), .hc_addr_in(hc_addr_in),
      .hc_value_in(hc_value_in), .hc_we_in(hc_we_in), .hc_valid_out(hc_valid_out),
      .hc_ready_in(hc_ready_in), .hc_addr_out(hc_addr_out), .hc_value_out(hc_value_out),
      .hc_we_out(hc_we_out), .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in),
      .lc_addr_out(lc_addr_out), .lc_value_out(lc_value_out), .we_out(we_out),
      .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out), .lc_addr_in(lc_addr_in),
      .lc_value_in(lc_value_in), .cl_in(cl_in), .cache_line_in(cache_line_in)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic [63:0] addr, input logic we, input logic [63:0] data);
      int n = 0;
      while (!hc_ready_out && n < 50) begin @(negedge clk_in); n++; end
      chk("req_ready", {63'd0, hc_ready_out}, 64'd1);
      hc_valid_in = 1'b1; hc_addr_in = addr; hc_we_in = we; hc_value_in = data;
      @(negedge clk_in);
      hc_valid_in = 1'b0; hc_we_in = 1'b0;
   endtask

   task automatic lc_req(input string tag, input logic exp_we, input logic [63:0] exp_addr,
                         input logic chk_val, input logic [63:0] exp_lo);
      int n = 0;
      while (!lc_valid_out && n < 50) begin @(negedge clk_in); n++; end
      chk({tag, "_lc_valid"}, {63'd0, lc_valid_out}, 64'd1);
      chk({tag, "_we"}, {63'd0, we_out}, {63'd0, exp_we});
      chk({tag, "_lc_addr"}, lc_addr_out, exp_addr);
      if (chk_val) chk({tag, "_wb_data"}, lc_value_out[63:0], exp_lo);
      lc_ready_in = 1'b1;
      @(negedge clk_in);
      lc_ready_in = 1'b0;
   endtask

   task automatic fill(input string tag, input logic [511:0] line, input logic [63:0] exp_cl_lo);
      int n = 0;
      while (!lc_ready_out && n < 50) begin @(negedge clk_in); n++; end
      chk({tag, "_lc_ready"}, {63'd0, lc_ready_out}, 64'd1);
      lc_valid_in = 1'b1; lc_value_in = line;
      @(negedge clk_in);
      lc_valid_in = 1'b0;
      chk({tag, "_cl"}, {63'd0, cl_in}, 64'd1);
      chk({tag, "_cl_line"}, cache_line_in[63:0], exp_cl_lo);
   endtask

   task automatic resp(input string tag, input logic [63:0] addr, input logic [63:0] val,
                       input logic we);
      int n = 0;
      while (!hc_valid_out && n < 50) begin @(negedge clk_in); n++; end
      chk({tag, "_hc_valid"}, {63'd0, hc_valid_out}, 64'd1);
      chk({tag, "_hc_addr"}, hc_addr_out, addr);
      chk({tag, "_hc_value"}, hc_value_out, val);
      chk({tag, "_hc_we"}, {63'd0, hc_we_out}, {63'd0, we});
      @(negedge clk_in);
      chk({tag, "_hold_value"}, hc_value_out, val);
      hc_ready_in = 1'b1;
      @(negedge clk_in);
      hc_ready_in = 1'b0;
      chk({tag, "_valid_drop"}, {63'd0, hc_valid_out}, 64'd0);
   endtask

   task automatic read_miss(input string tag, input logic [63:0] addr, input logic [511:0] line,
                            input logic [63:0] exp);
      do_req(addr, 1'b0, 64'd0);
      chk({tag, "_miss_lat"}, {63'd0, lc_valid_out}, 64'd1);
      lc_req(tag, 1'b0, {addr[63:6], 6'd0}, 1'b0, 64'd0);
      fill(tag, line, line[63:0]);
      resp(tag, addr, exp, 1'b0);
   endtask

   task automatic read_hit(input string tag, input logic [63:0] addr, input logic [63:0] exp);
      do_req(addr, 1'b0, 64'd0);
      chk({tag, "_hit_lat"}, {63'd0, hc_valid_out}, 64'd1);
      chk({tag, "_no_lc"}, {63'd0, lc_valid_out}, 64'd0);
      resp(tag, addr, exp, 1'b0);
   endtask

   initial begin
      int wb_count;
      int n;
      rst_N_in = 1'b1; cs_in = 1'b0; flush_in = 1'b0;
      hc_valid_in = 1'b0; hc_addr_in = '0; hc_value_in = '0; hc_we_in = 1'b0; hc_ready_in = 1'b0;
      lc_ready_in = 1'b0; lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
      repeat (3) @(negedge clk_in);
      rst_N_in = 1'b0;
      chk("rst_hc_valid", {63'd0, hc_valid_out}, 64'd0);
      chk("rst_lc_valid", {63'd0, lc_valid_out}, 64'd0);
      chk("rst_lc_ready", {63'd0, lc_ready_out}, 64'd0);
      chk("rst_cl", {63'd0, cl_in}, 64'd0);
      chk("rst_hc_value", hc_value_out, 64'd0);
      chk("rst_lc_addr", lc_addr_out, 64'd0);

      // chip select low: request must be ignored
      hc_valid_in = 1'b1; hc_addr_in = 64'h0;
      @(negedge clk_in);
      chk("cs_ready", {63'd0, hc_ready_out}, 64'd0);
      repeat (3) @(negedge clk_in);
      chk("cs_no_resp", {63'd0, hc_valid_out}, 64'd0);
      chk("cs_no_lc", {63'd0, lc_valid_out}, 64'd0);
      hc_valid_in = 1'b0; cs_in = 1'b1;

      read_miss("cold0", 64'h0, 512'h0123456789ABCDEF, 64'h0123456789ABCDEF);
      read_hit("hit0", 64'h0, 64'h0123456789ABCDEF);
      read_miss("cold4000", 64'h4000, 512'h0CAD456789AACDEF, 64'h0CAD456789AACDEF);
      read_hit("still0", 64'h0, 64'h0123456789ABCDEF);
      read_hit("hit4000", 64'h4000, 64'h0CAD456789AACDEF);
      read_miss("ev0", 64'h34000, 512'hDEADBEEF12345678, 64'hDEADBEEF12345678);
      read_miss("ev4000", 64'h44000, 512'h44, 64'h44);
      read_hit("hit34000", 64'h34000, 64'hDEADBEEF12345678);

      read_miss("wsel54", 64'h54, 512'hDEADBEEFDEADBEEF, 64'h0);
      read_hit("wsel40", 64'h40, 64'hDEADBEEFDEADBEEF);

      do_req(64'h0, 1'b1, 64'hFEDCBA9876543210);
      chk("wm_miss_lat", {63'd0, lc_valid_out}, 64'd1);
      lc_req("wm", 1'b0, 64'h0, 1'b0, 64'd0);
      fill("wm", 512'h0, 64'hFEDCBA9876543210);
      resp("wm", 64'h0, 64'hFEDCBA9876543210, 1'b1);
      read_hit("wm_rd", 64'h0, 64'hFEDCBA9876543210);

      read_miss("dv4000", 64'h4000, 512'h0CAD456789AACDEF, 64'h0CAD456789AACDEF);
      do_req(64'h34000, 1'b0, 64'd0);
      chk("dv_lat", {63'd0, lc_valid_out}, 64'd1);
      lc_req("dv_wb", 1'b1, 64'h0, 1'b1, 64'hFEDCBA9876543210);
      lc_req("dv_rd", 1'b0, 64'h34000, 1'b0, 64'd0);
      fill("dv", 512'hDEADBEEF12345678, 64'hDEADBEEF12345678);
      resp("dv", 64'h34000, 64'hDEADBEEF12345678, 1'b0);

      // write hit leaves exactly one dirty line for the flush
      do_req(64'h40, 1'b1, 64'h1111);
      chk("wh_hit_lat", {63'd0, hc_valid_out}, 64'd1);
      chk("wh_no_lc", {63'd0, lc_valid_out}, 64'd0);
      resp("wh", 64'h40, 64'h1111, 1'b1);

      flush_in = 1'b1;
      @(negedge clk_in);
      flush_in = 1'b0;
      chk("fl_ready", {63'd0, hc_ready_out}, 64'd0);
      wb_count = 0; n = 0;
      lc_ready_in = 1'b1;
      while (!hc_ready_out && n < 400) begin
         if (lc_valid_out) begin
            wb_count++;
            chk("fl_we", {63'd0, we_out}, 64'd1);
            chk("fl_addr", lc_addr_out, 64'h40);
            chk("fl_data", lc_value_out[63:0], 64'h1111);
         end
         @(negedge clk_in);
         n++;
      end
      lc_ready_in = 1'b0;
      chk("fl_done", {63'd0, hc_ready_out}, 64'd1);
      chk("fl_wb_count", 64'(wb_count), 64'd1);
      read_miss("postfl", 64'h4000, 512'h0CAD456789AACDEF, 64'h0CAD456789AACDEF);

      // reset while waiting for fill data
      do_req(64'h40, 1'b0, 64'd0);
      lc_req("rst", 1'b0, 64'h40, 1'b0, 64'd0);
      chk("rst_in_fill", {63'd0, lc_ready_out}, 64'd1);
      rst_N_in = 1'b1;
      @(negedge clk_in);
      rst_N_in = 1'b0;
      chk("rstf_lc_ready", {63'd0, lc_ready_out}, 64'd0);
      chk("rstf_hc_valid", {63'd0, hc_valid_out}, 64'd0);
      chk("rstf_cl", {63'd0, cl_in}, 64'd0);
      repeat (2) @(negedge clk_in);
      chk("rstf_no_resp", {63'd0, hc_valid_out}, 64'd0);
      read_miss("rstf_empty", 64'h4000, 512'h77, 64'h77);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
